// File: rtl/wb_slave_mux.sv
// rtl/wb_slave_mux.sv - Wishbone classic address decoder and response mux with fault log
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   wb_cyc/stb/adr/we/sel/i_dat  master request
//   wb_o_dat, wb_ack, wb_err     registered response to the master
//   s_stb                        per-slave strobe, one-hot or zero
//   s_cyc/adr/we/sel/dat         request forwarded to slaves (s_adr is window offset)
//   s_i_dat, s_ack               flat per-slave read data and acks
//   fault_clr                    clear the fault log
//   fault_valid/adr/cnt          sticky fault flag, last fault address, saturating count

module wb_slave_mux #(
    parameter int                         N_SLAVES = 8,
    parameter int                         ADDR_W   = 24,
    parameter int                         DATA_W   = 16,
    parameter int                         SEL_W    = 2,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLV_BASE = '0,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLV_END  = '0,
    parameter logic [N_SLAVES-1:0]        AUTO_ACK = '0,
    parameter int                         TIMEOUT  = 255
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       wb_cyc,
    input  logic                       wb_stb,
    input  logic [ADDR_W-1:0]          wb_adr,
    input  logic                       wb_we,
    input  logic [SEL_W-1:0]           wb_sel,
    input  logic [DATA_W-1:0]          wb_i_dat,
    output logic [DATA_W-1:0]          wb_o_dat,
    output logic                       wb_ack,
    output logic                       wb_err,
    output logic [N_SLAVES-1:0]        s_stb,
    output logic                       s_cyc,
    output logic [ADDR_W-1:0]          s_adr,
    output logic                       s_we,
    output logic [SEL_W-1:0]           s_sel,
    output logic [DATA_W-1:0]          s_dat,
    input  logic [N_SLAVES*DATA_W-1:0] s_i_dat,
    input  logic [N_SLAVES-1:0]        s_ack,
    input  logic                       fault_clr,
    output logic                       fault_valid,
    output logic [ADDR_W-1:0]          fault_adr,
    output logic [7:0]                 fault_cnt
);

    localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_ERR
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;

    logic               dec_hit;
    logic [IDX_W-1:0]   dec_idx;
    logic [ADDR_W-1:0]  dec_base;

    logic               sel_ack;
    logic               sel_auto;
    logic [DATA_W-1:0]  sel_dat;

    logic               take_slave;
    logic               take_data;
    logic               take_fault;

    // Plain forwarding of the master request.
    assign s_cyc = wb_cyc;
    assign s_we  = wb_we;
    assign s_sel = wb_sel;
    assign s_dat = wb_i_dat;

    // Walk from the highest index down so the lowest matching window wins.
    always_comb begin
        dec_hit  = 1'b0;
        dec_idx  = '0;
        dec_base = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (wb_adr >= SLV_BASE[i*ADDR_W +: ADDR_W] &&
                wb_adr <= SLV_END[i*ADDR_W +: ADDR_W]) begin
                dec_hit  = 1'b1;
                dec_idx  = IDX_W'(i);
                dec_base = SLV_BASE[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Response signals of the latched slave; compare-based so a non-power-of-two
    // N_SLAVES never indexes past the vectors.
    always_comb begin
        sel_ack  = 1'b0;
        sel_auto = 1'b0;
        sel_dat  = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_ack  = s_ack[i];
                sel_auto = AUTO_ACK[i];
                sel_dat  = s_i_dat[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_SLAVES; i++) begin
            s_stb[i] = (state == ST_WAIT) && (idx == IDX_W'(i)) && wb_cyc && wb_stb;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        take_slave = 1'b0;
        take_data  = 1'b0;
        take_fault = 1'b0;
        case (state)
            ST_IDLE: begin
                if (wb_cyc && wb_stb) begin
                    if (dec_hit) begin
                        state_nxt  = ST_WAIT;
                        take_slave = 1'b1;
                    end else begin
                        state_nxt  = ST_ERR;
                        take_fault = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                // Abort beats completion, completion beats timeout.
                if (!wb_cyc) begin
                    state_nxt = ST_IDLE;
                end else if (sel_ack || sel_auto) begin
                    state_nxt = ST_RESP;
                    take_data = 1'b1;
                end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                    state_nxt  = ST_ERR;
                    take_fault = 1'b1;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            ST_ERR:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign wb_ack = (state == ST_RESP);
    assign wb_err = (state == ST_ERR);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idx         <= '0;
            cnt         <= '0;
            s_adr       <= '0;
            wb_o_dat    <= '0;
            fault_valid <= 1'b0;
            fault_adr   <= '0;
            fault_cnt   <= '0;
        end else begin
            if (take_slave) begin
                idx   <= dec_idx;
                s_adr <= wb_adr - dec_base;
                cnt   <= '0;
            end else if (state == ST_WAIT) begin
                cnt <= cnt + 1'b1;
            end

            if (take_data) begin
                wb_o_dat <= sel_dat;
            end

            // A fault in the same cycle as a clear restarts the log at one.
            if (take_fault) begin
                fault_valid <= 1'b1;
                fault_adr   <= wb_adr;
                if (fault_clr) begin
                    fault_cnt <= 8'd1;
                end else if (fault_cnt != 8'hFF) begin
                    fault_cnt <= fault_cnt + 8'd1;
                end
            end else if (fault_clr) begin
                fault_valid <= 1'b0;
                fault_adr   <= '0;
                fault_cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_wb_slave_mux.sv
// tb/tb_wb_slave_mux.sv - randomized self-checking bench for wb_slave_mux

module tb_wb_slave_mux;

    localparam int AW = 24;
    localparam int DW = 16;
    localparam int SW = 2;
    localparam int N  = 4;
    localparam int TO = 8;

    localparam logic [N*AW-1:0] BASE = {24'hFFE000, 24'h100000, 24'h002008, 24'h002000};
    localparam logic [N*AW-1:0] ENDS = {24'hFFFFFF, 24'hFFDFFF, 24'h00200A, 24'h002003};
    localparam logic [N-1:0]    AUTO = 4'b1001;

    int unsigned mb [N] = '{32'h002000, 32'h002008, 32'h100000, 32'hFFE000};
    int unsigned me [N] = '{32'h002003, 32'h00200A, 32'hFFDFFF, 32'hFFFFFF};
    bit          ma [N] = '{1'b1, 1'b0, 1'b0, 1'b1};

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            wb_cyc, wb_stb, wb_we;
    logic [AW-1:0]   wb_adr;
    logic [SW-1:0]   wb_sel;
    logic [DW-1:0]   wb_i_dat;
    logic [DW-1:0]   wb_o_dat;
    logic            wb_ack, wb_err;
    logic [N-1:0]    s_stb;
    logic            s_cyc, s_we;
    logic [AW-1:0]   s_adr;
    logic [SW-1:0]   s_sel;
    logic [DW-1:0]   s_dat;
    logic [N*DW-1:0] s_i_dat;
    logic [N-1:0]    s_ack;
    logic            fault_clr;
    logic            fault_valid;
    logic [AW-1:0]   fault_adr;
    logic [7:0]      fault_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    logic          m_fv = 1'b0;
    logic [AW-1:0] m_fa = '0;
    int            m_fc = 0;

    wb_slave_mux #(
        .N_SLAVES(N), .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW),
        .SLV_BASE(BASE), .SLV_END(ENDS), .AUTO_ACK(AUTO), .TIMEOUT(TO)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_adr(wb_adr), .wb_we(wb_we),
        .wb_sel(wb_sel), .wb_i_dat(wb_i_dat), .wb_o_dat(wb_o_dat),
        .wb_ack(wb_ack), .wb_err(wb_err),
        .s_stb(s_stb), .s_cyc(s_cyc), .s_adr(s_adr), .s_we(s_we),
        .s_sel(s_sel), .s_dat(s_dat), .s_i_dat(s_i_dat), .s_ack(s_ack),
        .fault_clr(fault_clr), .fault_valid(fault_valid),
        .fault_adr(fault_adr), .fault_cnt(fault_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int decode(input logic [AW-1:0] a);
        for (int i = 0; i < N; i++) begin
            if (32'(a) >= mb[i] && 32'(a) <= me[i]) return i;
        end
        return -1;
    endfunction

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_faults(input string tag);
        chk({tag, "_fv"}, 32'(fault_valid), 32'(m_fv));
        chk({tag, "_fa"}, 32'(fault_adr), 32'(m_fa));
        chk({tag, "_fc"}, 32'(fault_cnt), 32'(m_fc));
    endtask

    // One master transfer. d = WAIT cycle (0-based) in which a non-auto slave acks,
    // d >= TO means it never acks. Entered and left just after a rising edge.
    task automatic xfer(input logic [AW-1:0] a, input bit we, input int d,
                        input logic [N*DW-1:0] sd, input bit clr_at_fault);
        int j, ack_c, err_c, endc;
        logic [N-1:0] own;
        logic [N-1:0] exp_stb;
        logic [DW-1:0] wd;
        j     = decode(a);
        ack_c = -1;
        err_c = -1;
        if (j < 0)         err_c = 1;
        else if (ma[j])    ack_c = 2;
        else if (d < TO)   ack_c = 2 + d;
        else               err_c = TO + 1;
        endc = (ack_c >= 0) ? ack_c : err_c;
        own  = (j >= 0) ? N'(1 << j) : '0;
        if (err_c >= 0) begin
            m_fv = 1'b1;
            m_fa = a;
            m_fc = clr_at_fault ? 1 : ((m_fc < 255) ? m_fc + 1 : 255);
        end
        wd       = DW'($urandom);
        s_i_dat  = sd;
        wb_cyc   = 1'b1;
        wb_stb   = 1'b1;
        wb_adr   = a;
        wb_we    = we;
        wb_sel   = SW'($urandom);
        wb_i_dat = wd;
        for (int c = 0; c <= endc; c++) begin
            s_ack = N'($urandom) & ~own;
            if (j >= 0 && !ma[j] && c == 1 + d) s_ack = s_ack | own;
            fault_clr = clr_at_fault && (err_c >= 0) && (c == endc - 1);
            @(negedge i_clk);
            chk("ack", 32'(wb_ack), 32'(c == ack_c));
            chk("err", 32'(wb_err), 32'(c == err_c));
            exp_stb = (j >= 0 && c >= 1 && c < endc) ? own : '0;
            chk("stb", 32'(s_stb), 32'(exp_stb));
            if (c == 0) begin
                chk("fwd", {6'd0, s_cyc, s_we, s_sel, s_dat, 6'd0}, {6'd0, 1'b1, we, wb_sel, wd, 6'd0});
            end
            if (j >= 0 && c >= 1) chk("sadr", 32'(s_adr), 32'((32'(a) - mb[j]) & 32'hFFFFFF));
            if (c == ack_c && !we) chk("rdat", 32'(wb_o_dat), 32'(sd[j*DW +: DW]));
            if (c == endc) chk_faults("flog");
            next_cycle();
        end
        wb_stb    = 1'b0;
        wb_cyc    = 1'b0;
        s_ack     = '0;
        fault_clr = 1'b0;
    endtask

    task automatic clear_log();
        fault_clr = 1'b1;
        next_cycle();
        fault_clr = 1'b0;
        m_fv = 1'b0;
        m_fa = '0;
        m_fc = 0;
        @(negedge i_clk);
        chk_faults("clr");
        next_cycle();
    endtask

    function automatic logic [AW-1:0] rand_addr();
        case ($urandom_range(0, 5))
            0: return AW'(32'h2000 + $urandom_range(0, 3));
            1: return AW'(32'h2008 + $urandom_range(0, 2));
            2: return AW'(32'h100000 + ($urandom % 32'hEFE000));
            3: return AW'(32'hFFE000 + $urandom_range(0, 32'h1FFF));
            4: return AW'(32'h2004 + $urandom_range(0, 3));
            default: return ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 32'h1FFF))
                                                        : AW'($urandom_range(32'h200B, 32'hFFFFF));
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        wb_adr = '0; wb_sel = '0; wb_i_dat = '0;
        s_i_dat = '0; s_ack = '0; fault_clr = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge i_clk);
        chk("rst_out", {wb_o_dat, 6'd0, wb_ack, wb_err, 4'd0, s_stb}, 32'd0);
        chk("rst_sadr", 32'(s_adr), 32'd0);
        chk_faults("rst");
        next_cycle();
        i_rst = 1'b0;
        next_cycle();

        // Directed scenarios from the test plan.
        xfer(24'hFFE005, 1'b0, 0, {16'hBEEF, 48'h0123_4567_89AB}, 1'b0);
        xfer(24'h002009, 1'b1, 3, {$urandom, $urandom}, 1'b0);
        xfer(24'h002005, 1'b0, 0, {$urandom, $urandom}, 1'b0);
        xfer(24'h100010, 1'b0, TO, {$urandom, $urandom}, 1'b0);
        xfer(24'h002000, 1'b0, 0, {$urandom, $urandom}, 1'b0);
        xfer(24'h100020, 1'b0, TO + 2, {$urandom, $urandom}, 1'b1);
        xfer(24'h00200A, 1'b0, TO - 1, {$urandom, $urandom}, 1'b0);

        // Abort: master drops cyc in the second WAIT cycle.
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_adr = 24'h002008; wb_we = 1'b0;
        next_cycle();
        @(negedge i_clk);
        chk("abt_stb", 32'(s_stb), 32'h2);
        next_cycle();
        wb_cyc = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            chk("abt_resp", {30'd0, wb_ack, wb_err}, 32'd0);
            chk("abt_stb0", 32'(s_stb), 32'd0);
            next_cycle();
            wb_stb = 1'b0;
        end
        xfer(24'h002001, 1'b0, 0, {$urandom, $urandom}, 1'b0);

        // Reset during WAIT, coincident with the slave ack.
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_adr = 24'h100040;
        next_cycle();
        @(negedge i_clk);
        chk("rw_stb", 32'(s_stb), 32'h4);
        next_cycle();
        i_rst = 1'b1;
        s_ack = 4'b0100;
        next_cycle();
        i_rst = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; s_ack = '0;
        m_fv = 1'b0; m_fa = '0; m_fc = 0;
        @(negedge i_clk);
        chk("rw_out", {wb_o_dat, 6'd0, wb_ack, wb_err, 4'd0, s_stb}, 32'd0);
        chk("rw_sadr", 32'(s_adr), 32'd0);
        chk_faults("rw");
        next_cycle();
        @(negedge i_clk);
        chk("rw_nopulse", {30'd0, wb_ack, wb_err}, 32'd0);
        next_cycle();

        // Randomized traffic, back-to-back where the coin says so.
        for (int t = 0; t < 150; t++) begin
            xfer(rand_addr(), 1'($urandom), $urandom_range(0, TO + 2),
                 {$urandom, $urandom}, $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) next_cycle();
            if ($urandom_range(0, 19) == 0) clear_log();
        end

        // Saturate the fault counter, then clear it.
        for (int t = 0; t < 260; t++) begin
            xfer(AW'($urandom_range(0, 32'h1FFF)), 1'b0, 0, {$urandom, $urandom}, 1'b0);
        end
        chk("sat", 32'(fault_cnt), 32'd255);
        clear_log();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
